// File: rtl/reset_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings, retry
// counter width and the default timing constants.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET  = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_SDRAM_INIT = 3'd2,
    ST_SYS_DELAY  = 3'd3,
    ST_RUN        = 3'd4
  } seq_state_e;

  localparam int RETRY_W = 4;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_LOCK_TIMEOUT       = 65536;
  localparam int DEF_INIT_TIMEOUT       = 262144;
  localparam int DEF_SYS_DELAY          = 256;
  localparam int DEF_LOSS_FILTER        = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the reset sequencer (master) and the PLL / SDRAM /
// domain-reset consumers (slave).
interface pll_reset_sequencer_if;

  logic                             locked;
  logic                             sdram_init_done;
  logic                             pll_rst;
  logic                             rst_sdram;
  logic                             rst_system;
  logic                             rst_io;
  logic                             ready;
  logic [2:0]                       seq_state;
  logic [reset_seq_pkg::RETRY_W-1:0] retry_count;
  logic                             fault;

  modport master (
    input  locked, sdram_init_done,
    output pll_rst, rst_sdram, rst_system, rst_io, ready,
           seq_state, retry_count, fault
  );

  modport slave (
    output locked, sdram_init_done,
    input  pll_rst, rst_sdram, rst_system, rst_io, ready,
           seq_state, retry_count, fault
  );

endinterface

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear, used for the
// asynchronous PLL lock and SDRAM init-done inputs.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and ordered SDRAM/system/IO reset
// release, with lock-loss filtering and saturating retry accounting.
module pll_reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int INIT_TIMEOUT       = DEF_INIT_TIMEOUT,
  parameter int SYS_DELAY          = DEF_SYS_DELAY,
  parameter int LOSS_FILTER        = DEF_LOSS_FILTER
) (
  input  logic                  clkin,
  input  logic                  resetn,
  pll_reset_sequencer_if.master bus
);

  localparam int TMR_MAX = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                max2(INIT_TIMEOUT, SYS_DELAY));
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int LOSS_W  = $clog2(LOSS_FILTER) + 1;

  localparam logic [TMR_W-1:0]  PLL_LAST  = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  INIT_LAST = TMR_W'(INIT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  SYS_LAST  = TMR_W'(SYS_DELAY - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);

  logic w_lock_s;
  logic w_done_s;

  sync2 u_sync_lock (.i_clk(clkin), .i_rst_n(resetn), .i_d(bus.locked),          .o_q(w_lock_s));
  sync2 u_sync_done (.i_clk(clkin), .i_rst_n(resetn), .i_d(bus.sdram_init_done), .o_q(w_done_s));

  seq_state_e         r_state;
  logic [TMR_W-1:0]   r_tmr;
  logic [STB_W-1:0]   r_stb;
  logic [LOSS_W-1:0]  r_loss;
  logic [RETRY_W-1:0] r_retry;
  logic               r_fault;
  logic               r_pll_rst;
  logic               r_rst_sdram;
  logic               r_rst_system;
  logic               r_rst_io;
  logic               r_ready;

  seq_state_e         w_state_nxt;
  logic [TMR_W-1:0]   w_tmr_nxt;
  logic [STB_W-1:0]   w_stb_nxt;
  logic [LOSS_W-1:0]  w_loss_nxt;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic               w_fault_nxt;
  logic               w_bump;
  logic               w_loss_active;
  logic               w_lost;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_PLL_RESET;
      r_tmr        <= '0;
      r_stb        <= '0;
      r_loss       <= '0;
      r_retry      <= '0;
      r_fault      <= 1'b0;
      r_pll_rst    <= 1'b1;
      r_rst_sdram  <= 1'b1;
      r_rst_system <= 1'b1;
      r_rst_io     <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmr        <= w_tmr_nxt;
      r_stb        <= w_stb_nxt;
      r_loss       <= w_loss_nxt;
      r_retry      <= w_retry_nxt;
      r_fault      <= w_fault_nxt;
      // Outputs decode the next state so each reset changes on the same edge as the state.
      r_pll_rst    <= (w_state_nxt == ST_PLL_RESET);
      r_rst_sdram  <= (w_state_nxt == ST_PLL_RESET) || (w_state_nxt == ST_WAIT_LOCK);
      r_rst_system <= (w_state_nxt != ST_SYS_DELAY) && (w_state_nxt != ST_RUN);
      r_rst_io     <= (w_state_nxt != ST_RUN);
      r_ready      <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fault_nxt   = r_fault;
    w_bump        = 1'b0;
    w_tmr_nxt     = '0;
    w_stb_nxt     = '0;
    w_loss_nxt    = '0;
    w_retry_nxt   = r_retry;
    w_loss_active = (r_state == ST_SDRAM_INIT) || (r_state == ST_SYS_DELAY) ||
                    (r_state == ST_RUN);
    w_lost        = w_loss_active && !w_lock_s && (r_loss == LOSS_LAST);

    case (r_state)
      ST_PLL_RESET: begin
        if (r_tmr == PLL_LAST) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock that qualifies on the timeout cycle still counts as success.
        if (w_lock_s && (r_stb == STB_LAST)) begin
          w_state_nxt = ST_SDRAM_INIT;
        end else if (r_tmr == LOCK_LAST) begin
          w_state_nxt = ST_PLL_RESET;
          w_bump      = 1'b1;
        end
      end
      ST_SDRAM_INIT: begin
        if (w_done_s) begin
          w_state_nxt = ST_SYS_DELAY;
        end else if (r_tmr == INIT_LAST) begin
          w_state_nxt = ST_PLL_RESET;
          w_fault_nxt = 1'b1;
          w_bump      = 1'b1;
        end
      end
      ST_SYS_DELAY: begin
        if (r_tmr == SYS_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_PLL_RESET;
      end
    endcase

    // Filtered lock loss overrides whatever the state decided this cycle.
    if (w_lost) begin
      w_state_nxt = ST_PLL_RESET;
      w_fault_nxt = r_fault;
      w_bump      = 1'b1;
    end

    if (w_state_nxt == r_state) begin
      w_tmr_nxt  = (r_state == ST_RUN) ? r_tmr : r_tmr + 1'b1;
      w_stb_nxt  = ((r_state == ST_WAIT_LOCK) && w_lock_s) ? r_stb + 1'b1 : '0;
      w_loss_nxt = (w_loss_active && !w_lock_s) ? r_loss + 1'b1 : '0;
    end

    if (w_bump && (r_retry != RETRY_MAX)) w_retry_nxt = r_retry + 1'b1;
  end

  assign bus.pll_rst     = r_pll_rst;
  assign bus.rst_sdram   = r_rst_sdram;
  assign bus.rst_system  = r_rst_system;
  assign bus.rst_io      = r_rst_io;
  assign bus.ready       = r_ready;
  assign bus.seq_state   = r_state;
  assign bus.retry_count = r_retry;
  assign bus.fault       = r_fault;

endmodule
